// File: rtl/seq_overlap_trim.sv
// seq_overlap_trim
//   Stitches consecutive job_pe sequence streams into one legal stream. When a
//   job's last match spills overlap_len bytes into the next job, those bytes
//   are already encoded, so they are removed from the head of the next job:
//   literals are shortened, matches shortened or demoted to literals, and fully
//   covered sequences dropped. Output is a one-deep registered ready/valid
//   stage.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   i_seq_*             : upstream sequence (valid, lit_len, match_len, offset,
//                         end_of_job, overlapped, overlap_len)
//   o_seq_ready         : upstream ready (combinational from output state)
//   o_seq_*             : trimmed, registered sequence (valid, lit_len,
//                         match_len, offset, end_of_job)
//   i_seq_ready         : downstream ready
//   o_drop_cnt          : sequences dropped entirely (saturating)
//   o_trim_cnt          : sequences modified but emitted (saturating)
module seq_overlap_trim #(
  parameter int JOB_LEN_LOG2       = 10,
  parameter int MAX_MATCH_LEN_LOG2 = 8,
  parameter int ADDR_WIDTH         = 16,
  parameter int MIN_MATCH_LEN      = 4,
  parameter int LW                 = JOB_LEN_LOG2 + 1,
  parameter int MW                 = MAX_MATCH_LEN_LOG2 + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_seq_valid,
  input  logic [LW-1:0]         i_seq_lit_len,
  input  logic [MW-1:0]         i_seq_match_len,
  input  logic [ADDR_WIDTH-1:0] i_seq_offset,
  input  logic                  i_seq_end_of_job,
  input  logic                  i_seq_overlapped,
  input  logic [LW-1:0]         i_seq_overlap_len,
  output logic                  o_seq_ready,
  output logic                  o_seq_valid,
  output logic [LW-1:0]         o_seq_lit_len,
  output logic [MW-1:0]         o_seq_match_len,
  output logic [ADDR_WIDTH-1:0] o_seq_offset,
  output logic                  o_seq_end_of_job,
  input  logic                  i_seq_ready,
  output logic [31:0]           o_drop_cnt,
  output logic [31:0]           o_trim_cnt
);

  // One bit wider than the larger field so L+M cannot overflow.
  localparam int SW = ((LW > MW) ? LW : MW) + 1;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  logic [LW-1:0]         skip;
  logic [LW-1:0]         skip_post;
  logic [LW-1:0]         skip_next;
  logic [LW-1:0]         ovl_skip;
  logic [SW-1:0]         s_w, l_w, m_w, lm_w, r_w, mr_w;
  logic [LW-1:0]         n_lit;
  logic [MW-1:0]         n_match;
  logic [ADDR_WIDTH-1:0] n_off;
  logic                  emit;
  logic                  is_trim;
  logic                  is_drop;
  logic                  accept;
  logic                  load;

  assign o_seq_ready = !o_seq_valid || i_seq_ready;
  assign accept      = i_seq_valid && o_seq_ready;
  assign load        = accept && emit;

  always_comb begin
    s_w       = SW'(skip);
    l_w       = SW'(i_seq_lit_len);
    m_w       = SW'(i_seq_match_len);
    lm_w      = l_w + m_w;
    r_w       = s_w - l_w;
    mr_w      = m_w - r_w;
    n_lit     = i_seq_lit_len;
    n_match   = i_seq_match_len;
    n_off     = i_seq_offset;
    emit      = 1'b1;
    is_trim   = 1'b0;
    is_drop   = 1'b0;
    skip_post = skip;
    if (skip != '0) begin
      // Full coverage is tested first so a sequence trimmed to nothing is
      // never emitted as an empty non-marker sequence.
      if (s_w >= lm_w) begin
        skip_post = LW'(s_w - lm_w);
        is_drop   = 1'b1;
        emit      = i_seq_end_of_job;
        n_lit     = '0;
        n_match   = '0;
        n_off     = '0;
      end else if (s_w <= l_w) begin
        n_lit     = LW'(l_w - s_w);
        skip_post = '0;
        is_trim   = 1'b1;
      end else begin
        skip_post = '0;
        is_trim   = 1'b1;
        n_lit     = '0;
        if (mr_w >= SW'(MIN_MATCH_LEN)) begin
          n_match = MW'(mr_w);
        end else begin
          // Remaining match too short for downstream: send as literals.
          n_lit   = LW'(mr_w);
          n_match = '0;
          n_off   = '0;
        end
      end
    end
    ovl_skip  = i_seq_overlapped ? i_seq_overlap_len : '0;
    skip_next = skip_post;
    if (i_seq_end_of_job) begin
      skip_next = (skip_post > ovl_skip) ? skip_post : ovl_skip;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip             <= '0;
      o_drop_cnt       <= '0;
      o_trim_cnt       <= '0;
      o_seq_valid      <= 1'b0;
      o_seq_lit_len    <= '0;
      o_seq_match_len  <= '0;
      o_seq_offset     <= '0;
      o_seq_end_of_job <= 1'b0;
    end else begin
      if (accept) begin
        skip <= skip_next;
        if (is_drop) o_drop_cnt <= sat_inc(o_drop_cnt);
        if (is_trim) o_trim_cnt <= sat_inc(o_trim_cnt);
      end
      // Output stage
      if (load) begin
        o_seq_valid      <= 1'b1;
        o_seq_lit_len    <= n_lit;
        o_seq_match_len  <= n_match;
        o_seq_offset     <= n_off;
        o_seq_end_of_job <= i_seq_end_of_job;
      end else if (i_seq_ready) begin
        o_seq_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_seq_overlap_trim.sv
module tb_seq_overlap_trim;
  localparam int LW = 11;
  localparam int MW = 9;
  localparam int AW = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_seq_valid = 1'b0;
  logic [LW-1:0] i_seq_lit_len = '0;
  logic [MW-1:0] i_seq_match_len = '0;
  logic [AW-1:0] i_seq_offset = '0;
  logic          i_seq_end_of_job = 1'b0;
  logic          i_seq_overlapped = 1'b0;
  logic [LW-1:0] i_seq_overlap_len = '0;
  logic          o_seq_ready;
  logic          o_seq_valid;
  logic [LW-1:0] o_seq_lit_len;
  logic [MW-1:0] o_seq_match_len;
  logic [AW-1:0] o_seq_offset;
  logic          o_seq_end_of_job;
  logic          i_seq_ready = 1'b1;
  logic [31:0]   o_drop_cnt;
  logic [31:0]   o_trim_cnt;

  seq_overlap_trim dut (
    .clk(clk), .rst(rst),
    .i_seq_valid(i_seq_valid), .i_seq_lit_len(i_seq_lit_len),
    .i_seq_match_len(i_seq_match_len), .i_seq_offset(i_seq_offset),
    .i_seq_end_of_job(i_seq_end_of_job), .i_seq_overlapped(i_seq_overlapped),
    .i_seq_overlap_len(i_seq_overlap_len), .o_seq_ready(o_seq_ready),
    .o_seq_valid(o_seq_valid), .o_seq_lit_len(o_seq_lit_len),
    .o_seq_match_len(o_seq_match_len), .o_seq_offset(o_seq_offset),
    .o_seq_end_of_job(o_seq_end_of_job), .i_seq_ready(i_seq_ready),
    .o_drop_cnt(o_drop_cnt), .o_trim_cnt(o_trim_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference model: byte-skip arithmetic on plain integers.
  typedef struct { int lit; int mat; int off; int eoj; } seq_t;
  seq_t expq[$];
  int m_skip = 0, m_drop = 0, m_trim = 0;

  function automatic void push_exp(int l, int m, int o, int e);
    seq_t s;
    s.lit = l; s.mat = m; s.off = o; s.eoj = e;
    expq.push_back(s);
  endfunction

  function automatic void model_accept(int L, int M, int off, int eoj, int ovl, int olen);
    int R;
    if (m_skip == 0) begin
      push_exp(L, M, off, eoj);
    end else if (m_skip >= L + M) begin
      m_skip -= L + M;
      m_drop++;
      if (eoj != 0) push_exp(0, 0, 0, 1);
    end else if (m_skip <= L) begin
      push_exp(L - m_skip, M, off, eoj);
      m_skip = 0;
      m_trim++;
    end else begin
      R = m_skip - L;
      m_skip = 0;
      m_trim++;
      if (M - R >= 4) push_exp(0, M - R, off, eoj);
      else            push_exp(M - R, 0, 0, eoj);
    end
    if (eoj != 0 && ovl != 0 && olen > m_skip) m_skip = olen;
  endfunction

  // Output monitor: every downstream handshake must match the model queue.
  int last_lit, last_mat, last_off, last_eoj;
  always @(negedge clk) begin
    seq_t e;
    if (!rst && o_seq_valid && i_seq_ready) begin
      chk("out_expected", (expq.size() > 0), 1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("out_lit", o_seq_lit_len, e.lit);
        chk("out_match", o_seq_match_len, e.mat);
        chk("out_off", o_seq_offset, e.off);
        chk("out_eoj", o_seq_end_of_job, e.eoj);
      end
      last_lit = o_seq_lit_len;  last_mat = o_seq_match_len;
      last_off = o_seq_offset;   last_eoj = o_seq_end_of_job;
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(int L, int M, int off, int eoj, int ovl, int olen);
    int n = 0;
    logic acc;
    i_seq_valid = 1'b1;
    i_seq_lit_len = LW'(L);
    i_seq_match_len = MW'(M);
    i_seq_offset = AW'(off);
    i_seq_end_of_job = eoj[0];
    i_seq_overlapped = ovl[0];
    i_seq_overlap_len = LW'(olen);
    do begin
      @(negedge clk);
      acc = o_seq_ready;
      @(posedge clk);
      n++;
    end while (!acc && n < 1000);
    if (!acc) chk("send_timeout", acc, 1);
    else model_accept(L, M, off, eoj, ovl, olen);
    #1 i_seq_valid = 1'b0;
  endtask

  task automatic expect_last(string tag, int l, int m, int o, int e);
    @(negedge clk);
    #1;
    chk({tag, "_lit"}, last_lit, l);
    chk({tag, "_match"}, last_mat, m);
    chk({tag, "_off"}, last_off, o);
    chk({tag, "_eoj"}, last_eoj, e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  bit   rand_on;
  time  t0, t1;

  initial begin
    #3;
    chk("rst_valid", o_seq_valid, 0);
    chk("rst_lit", o_seq_lit_len, 0);
    chk("rst_drop", o_drop_cnt, 0);
    chk("rst_trim", o_trim_cnt, 0);
    chk("rst_ready", o_seq_ready, 1);
    #9 rst = 1'b0;
    @(posedge clk); #1;

    // Passthrough with 1-cycle latency
    send(3, 5, 9, 0, 0, 0);
    chk("lat_valid", o_seq_valid, 1);
    chk("lat_lit", o_seq_lit_len, 3);
    send(2, 0, 0, 1, 0, 0);
    expect_last("pass", 2, 0, 0, 1);
    chk("pass_drop", o_drop_cnt, 0);
    chk("pass_trim", o_trim_cnt, 0);

    // Literal trim
    send(1, 0, 0, 1, 1, 4);
    send(6, 8, 20, 0, 0, 0);
    expect_last("littrim", 2, 8, 20, 0);
    chk("littrim_trim", o_trim_cnt, 1);

    // Match trim with demotion
    send(1, 0, 0, 1, 1, 7);
    send(3, 6, 11, 0, 0, 0);
    expect_last("demote", 2, 0, 0, 0);
    send(1, 0, 0, 1, 1, 5);
    send(3, 10, 7, 0, 0, 0);
    expect_last("mtrim", 0, 8, 7, 0);
    chk("mtrim_trim", o_trim_cnt, 3);

    // Drop and residual carry
    send(1, 0, 0, 1, 1, 12);
    send(4, 4, 1, 0, 0, 0);
    chk("drop1_cnt", o_drop_cnt, 1);
    send(1, 9, 3, 0, 0, 0);
    expect_last("resid", 0, 6, 3, 0);

    // Drop across a job end: marker preserved, skip = max(14, 6)
    send(1, 0, 0, 1, 1, 20);
    send(2, 3, 5, 0, 0, 0);
    send(1, 0, 0, 1, 1, 6);
    expect_last("marker", 0, 0, 0, 1);
    chk("marker_drop", o_drop_cnt, 3);
    send(20, 5, 1, 0, 0, 0);
    expect_last("carry14", 6, 5, 1, 0);
    chk("carry14_trim", o_trim_cnt, 5);

    // Backpressure
    idle(2);
    i_seq_ready = 1'b0;
    send(5, 4, 77, 0, 0, 0);
    fork
      send(7, 4, 3, 0, 0, 0);
      begin
        repeat (5) begin
          @(negedge clk);
          chk("bp_valid", o_seq_valid, 1);
          chk("bp_ready", o_seq_ready, 0);
          chk("bp_lit", o_seq_lit_len, 5);
          chk("bp_off", o_seq_offset, 77);
        end
        @(posedge clk); #1;
        i_seq_ready = 1'b1;
      end
    join
    t0 = $time;
    send(1, 4, 1, 0, 0, 0);
    send(2, 4, 2, 0, 0, 0);
    send(3, 4, 3, 0, 0, 0);
    send(4, 4, 4, 1, 0, 0);
    t1 = $time;
    chk("full_rate_cycles", (t1 - t0) / 10, 4);
    expect_last("bp_tail", 4, 4, 4, 1);
    chk("bp_queue_empty", expq.size(), 0);

    // Asynchronous reset mid-job with skip=9 and output held valid
    idle(2);
    i_seq_ready = 1'b0;
    send(1, 0, 0, 1, 1, 9);
    #1 rst = 1'b1;
    #1;
    chk("arst_valid", o_seq_valid, 0);
    chk("arst_lit", o_seq_lit_len, 0);
    chk("arst_eoj", o_seq_end_of_job, 0);
    chk("arst_drop", o_drop_cnt, 0);
    chk("arst_trim", o_trim_cnt, 0);
    chk("arst_ready", o_seq_ready, 1);
    expq.delete();
    m_skip = 0; m_drop = 0; m_trim = 0;
    #1 rst = 1'b0;
    i_seq_ready = 1'b1;
    @(posedge clk); #1;
    send(3, 5, 2, 0, 0, 0);
    expect_last("post_rst", 3, 5, 2, 0);
    chk("post_rst_trim", o_trim_cnt, 0);

    // Randomized traffic with random downstream stalls
    rand_on = 1'b1;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          send($urandom_range(0, 20), $urandom_range(0, 20), $urandom_range(0, 65535),
               ($urandom_range(0, 3) == 0) ? 1 : 0, $urandom_range(0, 1),
               $urandom_range(0, 40));
          if ($urandom_range(0, 4) == 0) idle(1);
        end
        rand_on = 1'b0;
      end
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          i_seq_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    i_seq_ready = 1'b1;
    for (int k = 0; k < 50 && expq.size() != 0; k++) @(posedge clk);
    idle(1);
    chk("rand_drain", expq.size(), 0);
    chk("rand_drop", o_drop_cnt, m_drop);
    chk("rand_trim", o_trim_cnt, m_trim);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
